// File: rtl/timer_pkg.sv
// Shared types and defaults for the countdown-timer dispatcher slice.
package timer_pkg;

    localparam int unsigned DW_DEF   = 5;
    localparam int unsigned WDOG_DEF = 40;

    typedef logic [DW_DEF-1:0] dur_t;

    typedef enum logic {
        StIdle,
        StWait
    } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; pushes to full and pops from empty are dropped.
module sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == LW'(DEPTH));
    assign empty   = (count_q == '0);
    assign level   = count_q;
    assign rdata   = mem[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/timer_dispatcher.sv
// Queues duration requests and issues them one at a time to the countdown timer,
// waiting for each completion pulse, with watchdog recovery if one never arrives.
module timer_dispatcher
    import timer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned WDOG  = WDOG_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    input  logic [DW-1:0]          req_dur,
    output logic                   req_ready,
    output logic [DW-1:0]          tmr_in,
    output logic                   tmr_in_valid,
    input  logic                   tmr_done,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    output logic                   drop_err,
    output logic                   timeout_err
);

    localparam int unsigned WW = $clog2(WDOG) + 1;

    state_e          state_q, state_d;
    logic [WW-1:0]   wdog_q, wdog_d;
    logic [DW-1:0]   tmr_in_q, tmr_in_d;
    logic            valid_q, valid_d;
    logic            drop_q, drop_d;
    logic            tout_q, tout_d;

    logic            fifo_full, fifo_empty, fifo_pop, fifo_push, accept;
    logic [DW-1:0]   fifo_head;

    // Zero durations would be ignored by the timer and stall the queue, so they never enter it.
    assign accept    = req_valid && req_ready;
    assign fifo_push = accept && (req_dur != '0);
    assign drop_d    = accept && (req_dur == '0);

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (req_dur),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    always_comb begin
        state_d  = state_q;
        wdog_d   = wdog_q;
        tmr_in_d = tmr_in_q;
        valid_d  = 1'b0;
        tout_d   = 1'b0;
        fifo_pop = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    tmr_in_d = fifo_head;
                    valid_d  = 1'b1;
                    wdog_d   = '0;
                    state_d  = StWait;
                end
            end
            StWait: begin
                // A completion on the last watchdog cycle still counts as on time.
                if (tmr_done) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        tmr_in_d = fifo_head;
                        valid_d  = 1'b1;
                        wdog_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (wdog_q == WW'(WDOG - 1)) begin
                    tout_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            wdog_q   <= '0;
            tmr_in_q <= '0;
            valid_q  <= 1'b0;
            drop_q   <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wdog_q   <= wdog_d;
            tmr_in_q <= tmr_in_d;
            valid_q  <= valid_d;
            drop_q   <= drop_d;
            tout_q   <= tout_d;
        end
    end

    // Ready comes from registered occupancy only, so a same-cycle pop never opens it early.
    assign req_ready    = !fifo_full;
    assign tmr_in       = tmr_in_q;
    assign tmr_in_valid = valid_q;
    assign busy         = (state_q == StWait);
    assign drop_err     = drop_q;
    assign timeout_err  = tout_q;

endmodule

// File: tb/tb_timer_dispatcher.sv
// Directed and randomized bench for timer_dispatcher against a queue-based reference model.
module tb_timer_dispatcher;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 5;
    localparam int unsigned WDOG  = 40;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   req_valid;
    logic [DW-1:0]          req_dur;
    logic                   req_ready;
    logic [DW-1:0]          tmr_in;
    logic                   tmr_in_valid;
    logic                   tmr_done;
    logic                   busy;
    logic [$clog2(DEPTH):0] level;
    logic                   drop_err;
    logic                   timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: pending requests plus what the outputs should show this cycle.
    int m_q[$];
    bit m_busy;
    int m_tmr_in;
    bit m_valid;
    bit m_drop;
    bit m_tout;
    int m_since;

    always #5 clk = ~clk;

    timer_dispatcher #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .WDOG  (WDOG)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_dur      (req_dur),
        .req_ready    (req_ready),
        .tmr_in       (tmr_in),
        .tmr_in_valid (tmr_in_valid),
        .tmr_done     (tmr_done),
        .busy         (busy),
        .level        (level),
        .drop_err     (drop_err),
        .timeout_err  (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s @cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_busy   = 1'b0;
        m_tmr_in = 0;
        m_valid  = 1'b0;
        m_drop   = 1'b0;
        m_tout   = 1'b0;
        m_since  = 0;
    endtask

    // Advance the model by one clock with the inputs present at that edge.
    task automatic model_step(input bit v, input int d, input bit done);
        bit pre_ready;
        bit do_pop;
        bit tout;
        pre_ready = (m_q.size() < DEPTH);
        do_pop    = (m_q.size() > 0) && (!m_busy || done);
        tout      = m_busy && !done && (m_since == WDOG - 1);
        m_valid   = 1'b0;
        m_drop    = 1'b0;
        m_tout    = tout;
        if (do_pop) begin
            m_tmr_in = m_q.pop_front();
            m_valid  = 1'b1;
            m_busy   = 1'b1;
            m_since  = 0;
        end else if (m_busy && (done || tout)) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_since++;
        end
        if (v && pre_ready) begin
            if (d != 0) m_q.push_back(d);
            else m_drop = 1'b1;
        end
    endtask

    task automatic check_model();
        chk("req_ready", 32'(req_ready), 32'(m_q.size() < DEPTH));
        chk("level", 32'(level), 32'(m_q.size()));
        chk("tmr_in", 32'(tmr_in), 32'(m_tmr_in));
        chk("tmr_in_valid", 32'(tmr_in_valid), 32'(m_valid));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("drop_err", 32'(drop_err), 32'(m_drop));
        chk("timeout_err", 32'(timeout_err), 32'(m_tout));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_level"}, 32'(level), 32'd0);
        chk({tag, "_tmr_in"}, 32'(tmr_in), 32'd0);
        chk({tag, "_valid"}, 32'(tmr_in_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_drop"}, 32'(drop_err), 32'd0);
        chk({tag, "_tout"}, 32'(timeout_err), 32'd0);
    endtask

    task automatic tick(input logic v, input logic [DW-1:0] d, input logic done);
        req_valid = v;
        req_dur   = d;
        tmr_done  = done;
        @(posedge clk);
        cyc++;
        model_step(v, int'(d), done);
        #1;
        check_model();
    endtask

    initial begin
        int n;
        int order[4];
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_dur   = '0;
        tmr_done  = 1'b0;
        model_reset();
        #12;
        check_reset_values("reset");
        rst_n = 1'b1;

        // Single request: issue two cycles after acceptance, busy until done.
        tick(1'b1, 5'd5, 1'b0);
        chk("single_no_early_valid", 32'(tmr_in_valid), 32'd0);
        tick(1'b0, 5'd0, 1'b0);
        chk("single_valid", 32'(tmr_in_valid), 32'd1);
        chk("single_tmr_in", 32'(tmr_in), 32'd5);
        tick(1'b0, 5'd0, 1'b0);
        chk("single_valid_one_cycle", 32'(tmr_in_valid), 32'd0);
        chk("single_busy", 32'(busy), 32'd1);
        tick(1'b0, 5'd0, 1'b0);
        tick(1'b0, 5'd0, 1'b1);
        chk("single_idle", 32'(busy), 32'd0);

        // Done while idle is ignored.
        tick(1'b0, 5'd0, 1'b1);
        chk("idle_done_busy", 32'(busy), 32'd0);
        chk("idle_done_tout", 32'(timeout_err), 32'd0);

        // Burst while waiting fills the FIFO; a held request waits for a pop.
        tick(1'b1, 5'd2, 1'b0);
        tick(1'b0, 5'd0, 1'b0);
        tick(1'b1, 5'd3, 1'b0);
        tick(1'b1, 5'd7, 1'b0);
        tick(1'b1, 5'd1, 1'b0);
        tick(1'b1, 5'd9, 1'b0);
        chk("burst_full_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 3; i++) tick(1'b1, 5'd12, 1'b0);
        chk("full_level", 32'(level), 32'd4);
        tick(1'b1, 5'd12, 1'b1);
        chk("pop_issue_3", 32'(tmr_in), 32'd3);
        chk("pop_level", 32'(level), 32'd3);
        tick(1'b1, 5'd12, 1'b0);
        chk("held_accepted_level", 32'(level), 32'd4);
        order = '{7, 1, 9, 12};
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 5'd0, 1'b0);
            tick(1'b0, 5'd0, 1'b1);
            chk("b2b_valid", 32'(tmr_in_valid), 32'd1);
            chk("b2b_order", 32'(tmr_in), 32'(order[i]));
        end
        tick(1'b0, 5'd0, 1'b1);
        chk("burst_idle", 32'(busy), 32'd0);

        // Zero duration is dropped with a single error pulse.
        tick(1'b1, 5'd0, 1'b0);
        chk("zero_drop", 32'(drop_err), 32'd1);
        chk("zero_level", 32'(level), 32'd0);
        tick(1'b0, 5'd0, 1'b0);
        chk("zero_drop_once", 32'(drop_err), 32'd0);
        chk("zero_no_issue", 32'(tmr_in_valid), 32'd0);

        // Watchdog: no completion for the issued 4, then the queued 6 goes out.
        tick(1'b1, 5'd4, 1'b0);
        tick(1'b1, 5'd6, 1'b0);
        chk("wdog_issue_4", 32'(tmr_in), 32'd4);
        n = 0;
        while (n < 60 && timeout_err !== 1'b1) begin
            tick(1'b0, 5'd0, 1'b0);
            n++;
        end
        chk("wdog_latency", 32'(n), 32'd40);
        tick(1'b0, 5'd0, 1'b0);
        chk("wdog_next_valid", 32'(tmr_in_valid), 32'd1);
        chk("wdog_next_dur", 32'(tmr_in), 32'd6);
        tick(1'b0, 5'd0, 1'b1);

        // Asynchronous reset with three entries queued while waiting.
        tick(1'b1, 5'd8, 1'b0);
        tick(1'b1, 5'd9, 1'b0);
        tick(1'b1, 5'd10, 1'b0);
        tick(1'b1, 5'd11, 1'b0);
        req_valid = 1'b0;
        tmr_done  = 1'b0;
        chk("pre_reset_level", 32'(level), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_values("held_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick(1'b0, 5'd0, 1'b0);

        // Randomized traffic; periodic quiet windows exercise the watchdog.
        for (int i = 0; i < 1500; i++) begin
            bit quiet;
            quiet = (i % 300) < 50;
            tick(1'($urandom_range(0, 1)), DW'($urandom_range(0, 31)),
                 quiet ? 1'b0 : ($urandom_range(0, 5) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_dispatcher.md
Name: timer_dispatcher

Overview:
Upstream feeder for the countdown timer. Buffers duration requests from a producer in a small FIFO and issues them one at a time on the timer's load interface (tmr_in / tmr_in_valid). It then waits for the timer's completion pulse (tmr_done, wired to the timer's out_valid) before issuing the next request. A watchdog recovers the block if a completion pulse never arrives.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16
DW, 5, duration width; matches timer input
WDOG, 40, max cycles spent in WAIT before timeout recovery

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  producer offers a duration this cycle
req_dur  input  DW  requested duration, 1..2^DW-1
req_ready  output  1  FIFO can accept; registered, equals !full
tmr_in  output  DW  duration driven to timer; registered
tmr_in_valid  output  1  one-cycle load strobe to timer; registered
tmr_done  input  1  timer completion pulse (timer out_valid)
busy  output  1  high in WAIT state
level  output  $clog2(DEPTH)+1  current FIFO occupancy
drop_err  output  1  one-cycle pulse: zero-duration request discarded
timeout_err  output  1  one-cycle pulse: watchdog expired

Behaviour:
- Reset (async, rst_n=0): all outputs 0 except req_ready=1. FIFO empty, level=0, FSM=IDLE, tmr_in=0, watchdog=0.
- Push: accepted when req_valid && req_ready && req_dur!=0. The written value is visible at the FIFO head the next cycle.
- Zero duration: req_valid && req_ready && req_dur==0 does not write. drop_err=1 on the following cycle. The timer ignores a zero load, so a zero request must never be issued.
- Push with req_ready=0 (full) is ignored silently; the producer must hold its request. req_ready depends only on the registered occupancy and never combinationally on a same-cycle pop.
- FSM states: IDLE, WAIT.
- IDLE with FIFO non-empty: pop the head. Next cycle tmr_in=head and tmr_in_valid=1 for exactly one cycle, FSM=WAIT, watchdog cleared.
- IDLE with FIFO empty: tmr_in_valid=0 and tmr_in holds its last value.
- WAIT: watchdog increments every cycle.
  - On tmr_done=1 with FIFO non-empty: pop immediately and issue the next request on the following cycle (back-to-back, no idle cycle). FSM stays in WAIT.
  - On tmr_done=1 with FIFO empty: go to IDLE.
  - If the watchdog reaches WDOG-1 without tmr_done: timeout_err pulses the next cycle and FSM goes to IDLE. The request that timed out is abandoned, not retried.
- tmr_done while in IDLE is ignored. No error is raised.
- Simultaneous push and pop in the same cycle: level is unchanged and both take effect. A push into an empty FIFO cannot be popped in the same cycle (one-cycle minimum latency).
- Pointers wrap modulo DEPTH. level is computed in DW-independent width, range 0..DEPTH.
- End-to-end latency: request accepted at cycle t (IDLE, FIFO empty) gives tmr_in_valid at t+2.
- Reset mid-operation discards all queued requests. No pulse is emitted.

Decomposition:
- Shared package timer_pkg holds: DW default, a typedef for the duration vector, an enum for the FSM states {IDLE, WAIT}, and the WDOG default.
- One sub-module is natural: sync_fifo (parameterised DEPTH/width; push, pop, full, empty, level).
- FSM, watchdog and output registers live in timer_dispatcher.

Test Plan:
- Single request: push 5 while idle → tmr_in=5, tmr_in_valid high one cycle two cycles later. busy stays high until tmr_done. Then IDLE, busy=0.
- Burst: push 3,7,1,9 on back-to-back cycles → req_ready drops after the fourth. Issues occur in order 3,7,1,9, each exactly one cycle after the preceding tmr_done.
- Zero duration: push 0 → no FIFO write, level stays 0, drop_err pulses once, tmr_in_valid never asserts.
- Full FIFO: with DEPTH=4 full and WAIT, hold req_valid with value 12 → ignored until a pop. In the pop cycle req_ready is still 0 and 12 is accepted the next cycle.
- Watchdog: issue 4 and never assert tmr_done → timeout_err pulses after WDOG=40 cycles. FSM returns to IDLE and the next queued entry issues.
- Reset mid-burst: assert rst_n=0 with 3 entries queued and in WAIT → outputs return to reset values asynchronously, level=0, and nothing is issued after release.
